// File: rtl/dvi_transmitter_if.sv
// Video-in / TMDS-out bundle of the DVI transmitter.
// The DUT takes the slave side; the pattern generator side is the master.
interface dvi_transmitter_if;
   logic [23:0] video_din;
   logic        video_hsync;
   logic        video_vsync;
   logic        video_de;
   logic [9:0]  tmds_data0;
   logic [9:0]  tmds_data1;
   logic [9:0]  tmds_data2;
   logic [9:0]  tmds_clk;

   modport master (
      output video_din, video_hsync, video_vsync, video_de,
      input  tmds_data0, tmds_data1, tmds_data2, tmds_clk
   );

   modport slave (
      input  video_din, video_hsync, video_vsync, video_de,
      output tmds_data0, tmds_data1, tmds_data2, tmds_clk
   );
endinterface

// File: rtl/dvi_transmitter.sv
// TMDS 8b/10b encoder for RGB888, one symbol per channel per pclk; latency 2 pclk.
// No backpressure: a pixel is accepted and a symbol emitted on every cycle.
module dvi_transmitter #(
   parameter logic [9:0] CLK_PATTERN = 10'b1111100000
) (
   input  logic             pclk,
   input  logic             reset,
   dvi_transmitter_if.slave vid
);

   localparam logic [9:0] TOKEN_00 = 10'b1101010100;
   localparam logic [9:0] TOKEN_01 = 10'b0010101011;
   localparam logic [9:0] TOKEN_10 = 10'b0101010100;
   localparam logic [9:0] TOKEN_11 = 10'b1010101011;

   // Stage 1: transition minimisation; bit 8 records XOR (1) vs XNOR (0).
   function automatic logic [8:0] tm_min(input logic [7:0] d);
      logic [3:0] n1;
      logic       use_xnor;
      logic [8:0] q;
      n1 = '0;
      for (int i = 0; i < 8; i++) n1 = n1 + 4'(d[i]);
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
      q    = '0;
      q[0] = d[0];
      for (int i = 1; i < 8; i++)
         q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q[8] = ~use_xnor;
      return q;
   endfunction

   // Stage 2: DC balance; returns {next_cnt, symbol}.
   function automatic logic [14:0] dc_bal(input logic [8:0] q, input logic signed [4:0] cnt);
      logic [3:0]        n1;
      logic [3:0]        n0;
      logic signed [4:0] s1;
      logic signed [4:0] s0;
      logic signed [4:0] nc;
      logic [9:0]        o;
      n1 = '0;
      for (int i = 0; i < 8; i++) n1 = n1 + 4'(q[i]);
      n0 = 4'd8 - n1;
      s1 = $signed({1'b0, n1});
      s0 = $signed({1'b0, n0});
      if (cnt == 5'sd0 || n1 == n0) begin
         o  = {~q[8], q[8], (q[8] ? q[7:0] : ~q[7:0])};
         nc = q[8] ? (cnt + s1 - s0) : (cnt + s0 - s1);
      end else if ((cnt > 5'sd0 && n1 > n0) || (cnt < 5'sd0 && n0 > n1)) begin
         o  = {1'b1, q[8], ~q[7:0]};
         nc = cnt + (q[8] ? 5'sd2 : 5'sd0) + s0 - s1;
      end else begin
         o  = {1'b0, q[8], q[7:0]};
         nc = cnt - (q[8] ? 5'sd0 : 5'sd2) + s1 - s0;
      end
      return {nc, o};
   endfunction

   function automatic logic [9:0] ctl_token(input logic c1, input logic c0);
      case ({c1, c0})
         2'b00:   return TOKEN_00;
         2'b01:   return TOKEN_01;
         2'b10:   return TOKEN_10;
         default: return TOKEN_11;
      endcase
   endfunction

   logic [8:0]        qm_s1 [3];
   logic              de_s1;
   logic              hsync_s1;
   logic              vsync_s1;
   logic signed [4:0] cnt   [3];
   logic [9:0]        dout  [3];
   logic [14:0]       bal   [3];

   always_comb begin
      for (int c = 0; c < 3; c++) bal[c] = dc_bal(qm_s1[c], cnt[c]);
   end

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         de_s1    <= 1'b0;
         hsync_s1 <= 1'b0;
         vsync_s1 <= 1'b0;
         for (int c = 0; c < 3; c++) begin
            qm_s1[c] <= '0;
            cnt[c]   <= '0;
            dout[c]  <= TOKEN_00;
         end
      end else begin
         qm_s1[0] <= tm_min(vid.video_din[7:0]);
         qm_s1[1] <= tm_min(vid.video_din[15:8]);
         qm_s1[2] <= tm_min(vid.video_din[23:16]);
         de_s1    <= vid.video_de;
         hsync_s1 <= vid.video_hsync;
         vsync_s1 <= vid.video_vsync;
         // Control cycles zero the disparity so each active run starts balanced.
         for (int c = 0; c < 3; c++) begin
            if (de_s1) begin
               dout[c] <= bal[c][9:0];
               cnt[c]  <= bal[c][14:10];
            end else begin
               dout[c] <= (c == 0) ? ctl_token(vsync_s1, hsync_s1) : TOKEN_00;
               cnt[c]  <= '0;
            end
         end
      end
   end

   assign vid.tmds_data0 = dout[0];
   assign vid.tmds_data1 = dout[1];
   assign vid.tmds_data2 = dout[2];
   assign vid.tmds_clk   = CLK_PATTERN;

endmodule

// File: tb/tb_dvi_transmitter.sv
// Bench for dvi_transmitter: directed token/data table, reset sequences, and a
// randomized run against a symbol-level DVI encoder model.
module tb_dvi_transmitter;

   logic pclk  = 1'b0;
   logic reset = 1'b1;

   dvi_transmitter_if vif ();

   dvi_transmitter dut (
      .pclk  (pclk),
      .reset (reset),
      .vid   (vif)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic        de;
      logic        vs;
      logic        hs;
      logic [23:0] din;
      logic [9:0]  e0;
      logic [9:0]  e1;
      logic [9:0]  e2;
   } vec_t;

   typedef struct packed {
      logic       de;
      logic [9:0] s0;
      logic [9:0] s1;
      logic [9:0] s2;
   } exp_t;

   int total = 0;
   int bad   = 0;
   int mcnt [3];
   logic [9:0] tok [4];

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic drive(input logic de, input logic vs, input logic hs, input logic [23:0] din);
      vif.video_de    = de;
      vif.video_vsync = vs;
      vif.video_hsync = hs;
      vif.video_din   = din;
   endtask

   // Model: pick the symbol from the encoding rules, then advance the running
   // disparity by the actual ones-minus-zeros of the emitted 10-bit word.
   function automatic logic [9:0] model_enc(input int ch, input logic [7:0] d);
      int         n1;
      int         a;
      bit         xn;
      logic [8:0] q;
      logic [9:0] s;
      n1   = $countones(d);
      xn   = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      q    = '0;
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = xn ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
      q[8] = !xn;
      a    = $countones(q[7:0]);
      if (mcnt[ch] == 0 || a == 4)
         s = {~q[8], q[8], (q[8] ? q[7:0] : ~q[7:0])};
      else if ((mcnt[ch] > 0 && a > 4) || (mcnt[ch] < 0 && a < 4))
         s = {1'b1, q[8], ~q[7:0]};
      else
         s = {1'b0, q[8], q[7:0]};
      mcnt[ch] += 2 * $countones(s) - 10;
      return s;
   endfunction

   function automatic exp_t model_pix(input logic de, input logic vs, input logic hs, input logic [23:0] din);
      exp_t e;
      e.de = de;
      if (!de) begin
         for (int c = 0; c < 3; c++) mcnt[c] = 0;
         e.s0 = tok[{vs, hs}];
         e.s1 = tok[0];
         e.s2 = tok[0];
      end else begin
         e.s0 = model_enc(0, din[7:0]);
         e.s1 = model_enc(1, din[15:8]);
         e.s2 = model_enc(2, din[23:16]);
      end
      return e;
   endfunction

   vec_t vt [12];
   exp_t q [$];

   initial begin
      exp_t e;
      int   disp [3];
      int   max_abs;
      logic de_r;

      tok[0] = 10'b1101010100;
      tok[1] = 10'b0010101011;
      tok[2] = 10'b0101010100;
      tok[3] = 10'b1010101011;
      for (int c = 0; c < 3; c++) begin
         mcnt[c] = 0;
         disp[c] = 0;
      end

      vt[0]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h354};
      vt[1]  = '{1'b0, 1'b0, 1'b1, 24'h000000, 10'h0AB, 10'h354, 10'h354};
      vt[2]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 10'h154, 10'h354, 10'h354};
      vt[3]  = '{1'b0, 1'b1, 1'b1, 24'h000000, 10'h2AB, 10'h354, 10'h354};
      vt[4]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 10'h100, 10'h100, 10'h100};
      vt[5]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 10'h3FF, 10'h3FF, 10'h3FF};
      vt[6]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 10'h100, 10'h100, 10'h100};
      vt[7]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h354};
      vt[8]  = '{1'b1, 1'b0, 1'b0, 24'hFFFFFF, 10'h200, 10'h200, 10'h200};
      vt[9]  = '{1'b0, 1'b0, 1'b0, 24'hFFFFFF, 10'h354, 10'h354, 10'h354};
      vt[10] = '{1'b1, 1'b0, 1'b0, 24'h000000, 10'h100, 10'h100, 10'h100};
      vt[11] = '{1'b0, 1'b1, 1'b1, 24'h000000, 10'h2AB, 10'h354, 10'h354};

      // Reset held, then released during a control period.
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      reset = 1'b1;
      repeat (3) tick();
      check("rst_data0", vif.tmds_data0, 10'h354);
      check("rst_data1", vif.tmds_data1, 10'h354);
      check("rst_data2", vif.tmds_data2, 10'h354);
      check("rst_clk",   vif.tmds_clk,   10'h3E0);
      reset = 1'b0;
      repeat (2) tick();
      check("post_rst_data0", vif.tmds_data0, 10'h354);
      check("post_rst_clk",   vif.tmds_clk,   10'h3E0);

      // Table streamed one entry per cycle; outputs lag the inputs by one tick here.
      for (int i = 0; i <= 12; i++) begin
         if (i < 12) drive(vt[i].de, vt[i].vs, vt[i].hs, vt[i].din);
         else        drive(1'b0, 1'b0, 1'b0, 24'h0);
         tick();
         if (i >= 1) begin
            check($sformatf("vec%0d_data0", i - 1), vif.tmds_data0, vt[i-1].e0);
            check($sformatf("vec%0d_data1", i - 1), vif.tmds_data1, vt[i-1].e1);
            check($sformatf("vec%0d_data2", i - 1), vif.tmds_data2, vt[i-1].e2);
         end
      end

      // Asynchronous reset in the middle of an active line.
      drive(1'b1, 1'b0, 1'b0, 24'h123456);
      repeat (4) tick();
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_data0", vif.tmds_data0, 10'h354);
      check("async_rst_data1", vif.tmds_data1, 10'h354);
      check("async_rst_data2", vif.tmds_data2, 10'h354);
      tick();
      check("async_rst_clk", vif.tmds_clk, 10'h3E0);
      drive(1'b1, 1'b0, 1'b0, 24'h000000);
      reset = 1'b0;
      tick();
      check("resume_c1_data0", vif.tmds_data0, 10'h354);
      tick();
      check("resume_c2_data0", vif.tmds_data0, 10'h100);
      check("resume_c2_data2", vif.tmds_data2, 10'h100);

      // Randomized run against the model, starting from a control period.
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      repeat (3) tick();
      max_abs = 0;
      de_r    = 1'b0;
      for (int n = 0; n <= 10000; n++) begin
         if (n == 10000) begin
            drive(1'b0, 1'b0, 1'b0, 24'h0);
         end else begin
            if ($urandom_range(0, 11) == 0) de_r = !de_r;
            drive(de_r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom));
         end
         q.push_back(model_pix(vif.video_de, vif.video_vsync, vif.video_hsync, vif.video_din));
         tick();
         if (q.size() == 2) begin
            e = q.pop_front();
            check("rand_data0", vif.tmds_data0, e.s0);
            check("rand_data1", vif.tmds_data1, e.s1);
            check("rand_data2", vif.tmds_data2, e.s2);
            if (e.de) begin
               disp[0] += 2 * $countones(vif.tmds_data0) - 10;
               disp[1] += 2 * $countones(vif.tmds_data1) - 10;
               disp[2] += 2 * $countones(vif.tmds_data2) - 10;
               for (int c = 0; c < 3; c++) begin
                  if (disp[c] > max_abs)  max_abs = disp[c];
                  if (-disp[c] > max_abs) max_abs = -disp[c];
               end
            end else begin
               for (int c = 0; c < 3; c++) disp[c] = 0;
            end
         end
      end

      total++;
      if (max_abs > 8) begin
         bad++;
         $display("FAIL disparity_bound: got max |disparity|=%0d expected <=8", max_abs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
